// File: rtl/barrett_red_if.sv
// Handshake bundle for the Barrett reducer: product/tag in, residue/tag out,
// with valid/ready flow control on each side.
interface barrett_red_if #(
  parameter int wI = 32,
  parameter int wT = 8
);
  localparam int wO = 2 * wI;

  logic          iValid;
  logic          oReady;
  logic [wO-1:0] iD;
  logic [wT-1:0] iTag;
  logic          oValid;
  logic          iReady;
  logic [wI-1:0] oR;
  logic [wT-1:0] oTag;

  modport slave (
    input  iValid, iD, iTag, iReady,
    output oReady, oValid, oR, oTag
  );

  modport master (
    output iValid, iD, iTag, iReady,
    input  oReady, oValid, oR, oTag
  );
endinterface

// File: rtl/barrett_red.sv
// Four-stage pipelined Barrett reducer: oR = iD mod Q for iD < Q^2, with a tag
// carried alongside each word and a single global advance enable.
module barrett_red #(
  parameter int             wI = 32,
  parameter int             wT = 8,
  parameter int             wO = 2 * wI,
  parameter logic [wI-1:0]  Q  = 32'hFFFF_FFFB,
  parameter logic [wI:0]    MU = 33'h1_0000_0005
) (
  input  logic          iClk,
  input  logic          iRstn,
  barrett_red_if.slave  bus
);

  // Residue arithmetic only needs wI+2 bits: the true remainder is below 3Q.
  localparam logic [wI+1:0] QX = {2'b00, Q};

  function automatic logic [wI+1:0] sub_q(input logic [wI+1:0] r);
    return (r >= QX) ? (r - QX) : r;
  endfunction

  function automatic logic [wI-1:0] reduce_final(input logic [wI+1:0] r);
    logic [wI+1:0] t;
    t = sub_q(sub_q(r));
    return wI'(t);
  endfunction

  logic                en;
  logic [wI:0]         q1;
  logic [wI:0]         q3;
  logic [wI+1:0]       q3q;

  logic                vld_p1_q, vld_p1_d;
  logic [wO-1:0]       d_p1_q,   d_p1_d;
  logic [wT-1:0]       tag_p1_q, tag_p1_d;

  logic                vld_p2_q, vld_p2_d;
  logic [2*wI+1:0]     q2_p2_q,  q2_p2_d;
  logic [wI+1:0]       dlo_p2_q, dlo_p2_d;
  logic [wT-1:0]       tag_p2_q, tag_p2_d;

  logic                vld_p3_q, vld_p3_d;
  logic [wI+1:0]       r_p3_q,   r_p3_d;
  logic [wT-1:0]       tag_p3_q, tag_p3_d;

  logic                vld_p4_q, vld_p4_d;
  logic [wI-1:0]       r_p4_q,   r_p4_d;
  logic [wT-1:0]       tag_p4_q, tag_p4_d;

  always_comb begin
    en   = bus.iReady | ~vld_p4_q;
    q1   = (wI+1)'(d_p1_q >> (wI - 1));
    q3   = (wI+1)'(q2_p2_q >> (wI + 1));
    q3q  = {1'b0, q3} * QX;

    vld_p1_d = vld_p1_q;
    d_p1_d   = d_p1_q;
    tag_p1_d = tag_p1_q;
    vld_p2_d = vld_p2_q;
    q2_p2_d  = q2_p2_q;
    dlo_p2_d = dlo_p2_q;
    tag_p2_d = tag_p2_q;
    vld_p3_d = vld_p3_q;
    r_p3_d   = r_p3_q;
    tag_p3_d = tag_p3_q;
    vld_p4_d = vld_p4_q;
    r_p4_d   = r_p4_q;
    tag_p4_d = tag_p4_q;

    if (en) begin
      // S1: capture product and tag
      vld_p1_d = bus.iValid;
      d_p1_d   = bus.iD;
      tag_p1_d = bus.iTag;
      // S2: quotient estimate product q1*MU
      vld_p2_d = vld_p1_q;
      q2_p2_d  = {{(wI+1){1'b0}}, q1} * {{(wI+1){1'b0}}, MU};
      dlo_p2_d = d_p1_q[wI+1:0];
      tag_p2_d = tag_p1_q;
      // S3: raw remainder modulo 2^(wI+2)
      vld_p3_d = vld_p2_q;
      r_p3_d   = dlo_p2_q - q3q;
      tag_p3_d = tag_p2_q;
      // S4: up to two conditional subtractions of Q
      vld_p4_d = vld_p3_q;
      r_p4_d   = reduce_final(r_p3_q);
      tag_p4_d = tag_p3_q;
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      vld_p1_q <= 1'b0;
      d_p1_q   <= '0;
      tag_p1_q <= '0;
      vld_p2_q <= 1'b0;
      q2_p2_q  <= '0;
      dlo_p2_q <= '0;
      tag_p2_q <= '0;
      vld_p3_q <= 1'b0;
      r_p3_q   <= '0;
      tag_p3_q <= '0;
      vld_p4_q <= 1'b0;
      r_p4_q   <= '0;
      tag_p4_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      d_p1_q   <= d_p1_d;
      tag_p1_q <= tag_p1_d;
      vld_p2_q <= vld_p2_d;
      q2_p2_q  <= q2_p2_d;
      dlo_p2_q <= dlo_p2_d;
      tag_p2_q <= tag_p2_d;
      vld_p3_q <= vld_p3_d;
      r_p3_q   <= r_p3_d;
      tag_p3_q <= tag_p3_d;
      vld_p4_q <= vld_p4_d;
      r_p4_q   <= r_p4_d;
      tag_p4_q <= tag_p4_d;
    end
  end

  assign bus.oReady = en;
  assign bus.oValid = vld_p4_q;
  assign bus.oR     = r_p4_q;
  assign bus.oTag   = tag_p4_q;

endmodule
